// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler: round-robin arbitration of ALU/LSU results onto the
// register file write port, plus a per-register pending-write scoreboard.
module rf_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic [AW-1:0]   q_rs1,
    input  logic [AW-1:0]   q_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [XLEN-1:0] wr_data
);

    localparam int NREG = 1 << AW;
    localparam logic PRIO_ALU = 1'b0;
    localparam logic PRIO_LSU = 1'b1;

    logic            prio;
    logic [1:0]      cnt [NREG];
    logic            xfer;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            commit_hit;
    logic            issue_inc;

    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst) begin
            if (alu_valid && (!lsu_valid || prio == PRIO_ALU))
                alu_ready = 1'b1;
            else if (lsu_valid)
                lsu_ready = 1'b1;
        end
    end

    assign xfer     = alu_ready | lsu_ready;
    assign sel_rd   = lsu_ready ? lsu_rd : alu_rd;
    assign sel_data = lsu_ready ? lsu_data : alu_data;

    // A commit landing this cycle frees a slot, so a saturated counter can still accept.
    assign commit_hit  = wr_en && (wr_addr == issue_rd);
    assign issue_ready = (issue_rd == '0) || (cnt[issue_rd] != 2'd3) || commit_hit;
    assign issue_inc   = issue_en && issue_ready && (issue_rd != '0);

    assign rs1_busy = (q_rs1 != '0) && (cnt[q_rs1] != 2'd0);
    assign rs2_busy = (q_rs2 != '0) && (cnt[q_rs2] != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            prio    <= PRIO_ALU;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int i = 0; i < NREG; i++)
                cnt[i] <= 2'd0;
        end else begin
            if (alu_ready)
                prio <= PRIO_LSU;
            else if (lsu_ready)
                prio <= PRIO_ALU;

            wr_en <= xfer && (sel_rd != '0);
            if (xfer && (sel_rd != '0)) begin
                wr_addr <= sel_rd;
                wr_data <= sel_data;
            end

            for (int i = 1; i < NREG; i++) begin
                if ((issue_inc && issue_rd == AW'(i)) && !(wr_en && wr_addr == AW'(i)))
                    cnt[i] <= cnt[i] + 2'd1;
                else if (!(issue_inc && issue_rd == AW'(i)) && (wr_en && wr_addr == AW'(i))
                         && cnt[i] != 2'd0)
                    cnt[i] <= cnt[i] - 2'd1;
            end
        end
    end

endmodule
